i2s_tx_master: RTL and testbench

//   I2S master transmitter: the output end of the mic-array I2S link. It takes beamformed

---
 rtl/i2s_tx_master_pkg.sv | 20 ++
 rtl/i2s_tx_master_if.sv | 14 +
 rtl/i2s_tx_master_bclk_gen.sv | 37 +++
 rtl/i2s_tx_master.sv | 127 ++++++++++++
 tb/tb_i2s_tx_master.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/i2s_tx_master_pkg.sv
// Shared types, default geometry and the word-select helper for the I2S master transmitter.
package i2s_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_SLOT_W   = 32;
    localparam int DEF_BCLK_DIV = 4;
    localparam int FRAME_W      = 2 * DEF_SLOT_W;
    localparam int K_W          = $clog2(FRAME_W);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } i2s_state_t;

    // lr leads the data by one bit_clk, so it looks at the slot of bit k+1.
    function automatic logic lr_level(input int k, input int slot_w);
        return ((k + 1) % (2 * slot_w)) >= slot_w;
    endfunction

endpackage

// File: rtl/i2s_tx_master_if.sv
// Sample-pair stream from the beamformer into the I2S transmitter.
interface i2s_tx_master_if
    import i2s_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_master_bclk_gen.sv
// Bit clock divider: div_cnt, registered bit_clk_o and the falling-edge strobe edge_evt.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_clk_o,
    output logic edge_evt
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] HALF     = DW'(BCLK_DIV / 2);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;

    assign div_nxt  = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
    // Combinational so the first enabled clk already counts as edge event k=0.
    assign edge_evt = en && (div_cnt == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bit_clk_o <= 1'b0;
        end else if (!en) begin
            div_cnt   <= '0;
            bit_clk_o <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            bit_clk_o <= (div_nxt >= HALF);
        end
    end
endmodule

// File: rtl/i2s_tx_master.sv
// I2S (Philips) master transmitter: stream in, bit_clk/lr_clk/sd out.
// Build option I2S_TX_HOLD_EN: repeat the last pair on underrun instead of sending silence.
module i2s_tx_master
    import i2s_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SLOT_W   = DEF_SLOT_W,
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    i2s_tx_master_if.slave    s,
    output logic              bit_clk_o,
    output logic              lr_clk_o,
    output logic              sd_o,
    output logic              underrun_o
);
    localparam int FRAME_LEN = 2 * SLOT_W;
    localparam int KW        = $clog2(FRAME_LEN);
    localparam logic [KW-1:0] K_LAST = KW'(FRAME_LEN - 1);

    i2s_state_t        state;
    logic [KW-1:0]     k;
    logic              hold_full;
    logic [DATA_W-1:0] hold_l, hold_r;
    logic [DATA_W-1:0] shift_l, shift_r;
    logic [DATA_W-1:0] ld_l, ld_r;
    logic              edge_evt;
    logic              xfer;
    logic              frame_load;
`ifdef I2S_TX_HOLD_EN
    logic [DATA_W-1:0] last_l, last_r;
`endif

    i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ena),
        .bit_clk_o (bit_clk_o),
        .edge_evt  (edge_evt)
    );

    assign s.s_ready  = ~hold_full;
    assign xfer       = s.s_valid & ~hold_full;
    assign frame_load = edge_evt && (state == ST_IDLE || k == '0);

    // Pair entering the shift registers at frame start: hold, then bypass, then underrun fill.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch behind.
        ld_l = '0;
        ld_r = '0;
        if (hold_full) begin
            ld_l = hold_l;
            ld_r = hold_r;
        end else if (s.s_valid) begin
            ld_l = s.s_left;
            ld_r = s.s_right;
        end
`ifdef I2S_TX_HOLD_EN
        else begin
            ld_l = last_l;
            ld_r = last_r;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            k          <= '0;
            lr_clk_o   <= 1'b0;
            sd_o       <= 1'b0;
            underrun_o <= 1'b0;
            hold_full  <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            shift_l    <= '0;
            shift_r    <= '0;
`ifdef I2S_TX_HOLD_EN
            last_l     <= '0;
            last_r     <= '0;
`endif
        end else begin
            underrun_o <= 1'b0;

            // A bypass transfer at frame start skips the hold register entirely.
            if (xfer && !frame_load) begin
                hold_l    <= s.s_left;
                hold_r    <= s.s_right;
                hold_full <= 1'b1;
            end

            if (!ena) begin
                state    <= ST_IDLE;
                k        <= '0;
                lr_clk_o <= 1'b0;
                sd_o     <= 1'b0;
            end else begin
                state <= ST_RUN;
                if (edge_evt) begin
                    k        <= (k == K_LAST) ? '0 : k + KW'(1);
                    lr_clk_o <= lr_level(int'(k), SLOT_W);
                    if (frame_load) begin
                        hold_full  <= 1'b0;
                        underrun_o <= ~hold_full & ~s.s_valid;
                        sd_o       <= ld_l[DATA_W-1];
                        shift_l    <= ld_l << 1;
                        shift_r    <= ld_r;
`ifdef I2S_TX_HOLD_EN
                        last_l     <= ld_l;
                        last_r     <= ld_r;
`endif
                    end else if (int'(k) < DATA_W) begin
                        sd_o    <= shift_l[DATA_W-1];
                        shift_l <= shift_l << 1;
                    end else if (int'(k) >= SLOT_W && int'(k) < SLOT_W + DATA_W) begin
                        sd_o    <= shift_r[DATA_W-1];
                        shift_r <= shift_r << 1;
                    end else begin
                        sd_o <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed bench for i2s_tx_master: framing, underrun, backpressure, bypass, ena drop, reset.
module tb_i2s_tx_master;
    import i2s_pkg::*;

    localparam logic [63:0] LR_EXP = 64'h7FFF_FFFF_8000_0000;

    logic clk;
    logic rst_n;
    logic ena;
    logic bit_clk_o, lr_clk_o, sd_o, underrun_o;

    int n_assert = 0;
    int n_fail   = 0;

    i2s_tx_master_if #(.DATA_W(16)) sif ();

    i2s_tx_master #(.DATA_W(16), .SLOT_W(32), .BCLK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .s          (sif),
        .bit_clk_o  (bit_clk_o),
        .lr_clk_o   (lr_clk_o),
        .sd_o       (sd_o),
        .underrun_o (underrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected sd_o per bit position j (bit j of the result) for one frame.
    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) begin
            v[j]      = l[15-j];
            v[32 + j] = r[15-j];
        end
        return v;
    endfunction

    // Starts just after an edge-event posedge; samples one bit per 4 clk.
    task automatic grab(input int nbits, input bit bp,
                        output logic [63:0] sdv, output logic [63:0] lrv,
                        output int ur, output int bclk_err, output int xfers, output int rdy_hi);
        logic xf;
        sdv = '0; lrv = '0; ur = 0; bclk_err = 0; xfers = 0; rdy_hi = 0;
        for (int j = 0; j < nbits; j++) begin
            sdv[j] = sd_o;
            lrv[j] = lr_clk_o;
            for (int p = 0; p < 4; p++) begin
                if (bit_clk_o !== ((p == 1) || (p == 2))) bclk_err++;
                if (underrun_o === 1'b1) ur++;
                if (sif.s_ready === 1'b1) rdy_hi++;
                xf = sif.s_valid & sif.s_ready;
                tick();
                if (xf) begin
                    xfers++;
                    if (bp) begin
                        sif.s_left  = sif.s_left + 16'h0101;
                        sif.s_right = sif.s_right - 16'h0101;
                    end
                end
            end
        end
    endtask

    logic [63:0] sdv, lrv, sdv2, lrv2, f_exp;
    int ur, be, xf, rh;
    int idle_bad;

    initial begin
        rst_n = 1'b0; ena = 1'b0;
        sif.s_valid = 1'b0; sif.s_left = '0; sif.s_right = '0;
        repeat (2) tick();
        check("reset_outputs", 64'({bit_clk_o, lr_clk_o, sd_o, underrun_o, sif.s_ready}), 64'h1);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_outputs", 64'({bit_clk_o, lr_clk_o, sd_o, underrun_o, sif.s_ready}), 64'h1);

        // Single frame
        sif.s_valid = 1'b1; sif.s_left = 16'hA5C3; sif.s_right = 16'h0F0F;
        tick();
        sif.s_valid = 1'b0;
        check("hold_full_ready", 64'(sif.s_ready), 64'h0);
        ena = 1'b1;
        tick();
        grab(64, 1'b0, sdv, lrv, ur, be, xf, rh);
        check("f1_sd", sdv, exp_frame(16'hA5C3, 16'h0F0F));
        check("f1_lr", lrv, LR_EXP);
        check("f1_underrun", 64'(ur), 64'd0);
        check("f1_bclk", 64'(be), 64'd0);
        check("f1_ready_all", 64'(rh), 64'd256);

        // Underrun
        grab(64, 1'b0, sdv, lrv, ur, be, xf, rh);
`ifdef I2S_TX_HOLD_EN
        f_exp = exp_frame(16'hA5C3, 16'h0F0F);
`else
        f_exp = '0;
`endif
        check("f2_sd", sdv, f_exp);
        check("f2_underrun", 64'(ur), 64'd1);

        // Backpressure: s_valid held high, data advances after each transfer
        sif.s_valid = 1'b1; sif.s_left = 16'h1234; sif.s_right = 16'h4321;
        grab(64, 1'b1, sdv, lrv, ur, be, xf, rh);
        check("f3_xfers", 64'(xf), 64'd1);
        check("f3_ready_hi", 64'(rh), 64'd1);
        check("f3_underrun", 64'(ur), 64'd1);
        grab(64, 1'b1, sdv, lrv, ur, be, xf, rh);
        check("f4_sd", sdv, exp_frame(16'h1234, 16'h4321));
        check("f4_xfers", 64'(xf), 64'd1);
        check("f4_ready_hi", 64'(rh), 64'd1);
        check("f4_underrun", 64'(ur), 64'd0);
        grab(64, 1'b1, sdv, lrv, ur, be, xf, rh);
        check("f5_sd", sdv, exp_frame(16'h1335, 16'h4220));
        check("f5_xfers", 64'(xf), 64'd1);
        check("f5_lr", lrv, LR_EXP);
        sif.s_valid = 1'b0;

        // Mid-frame ena drop at k=20 with a pair pushed into the hold register first
        f_exp = exp_frame(16'h1436, 16'h411F);
        grab(10, 1'b0, sdv, lrv, ur, be, xf, rh);
        sif.s_valid = 1'b1; sif.s_left = 16'hCAFE; sif.s_right = 16'hBEEF;
        grab(10, 1'b0, sdv2, lrv2, ur, be, xf, rh);
        sif.s_valid = 1'b0;
        check("f6_sd_lo", 64'(sdv[9:0]), 64'(f_exp[9:0]));
        check("f6_sd_hi", 64'(sdv2[9:0]), 64'(f_exp[19:10]));
        check("f6_push", 64'(xf), 64'd1);
        ena = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({bit_clk_o, lr_clk_o, sd_o, underrun_o, sif.s_ready} !== 5'b0) idle_bad++;
        end
        check("drop_idle_outputs", 64'(idle_bad), 64'd0);
        ena = 1'b1;
        tick();
        check("reenable_lr_k0", 64'(lr_clk_o), 64'd0);
        grab(63, 1'b0, sdv, lrv, ur, be, xf, rh);
        check("f7_sd", sdv, exp_frame(16'hCAFE, 16'hBEEF));
        check("f7_lr", lrv, LR_EXP);
        check("f7_underrun", 64'(ur), 64'd0);

        // Bypass: valid first asserted in the cycle of event k=0 with hold empty
        repeat (3) tick();
        sif.s_valid = 1'b1; sif.s_left = 16'h8001; sif.s_right = 16'h7FFE;
        tick();
        sif.s_valid = 1'b0;
        check("bypass_ready", 64'(sif.s_ready), 64'd1);
        grab(64, 1'b0, sdv, lrv, ur, be, xf, rh);
        check("f8_sd", sdv, exp_frame(16'h8001, 16'h7FFE));
        check("f8_underrun", 64'(ur), 64'd0);

        // Asynchronous reset mid-frame with the hold register full
        tick();
        sif.s_valid = 1'b1; sif.s_left = 16'h0001; sif.s_right = 16'h0002;
        tick();
        sif.s_valid = 1'b0;
        check("pre_reset_ready", 64'(sif.s_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 64'({bit_clk_o, lr_clk_o, sd_o, underrun_o, sif.s_ready}), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
